// File: rtl/rdid_responder_if.sv
// SPI pin bundle plus the responder's decoded-command status outputs.
// master: the SPI initiator side, slave: the RDID responder.
interface rdid_responder_if;
   logic       sclk;
   logic       cs_n;
   logic       mosi;
   logic       miso;
   logic       cmd_valid;
   logic [7:0] cmd_byte;
   logic       busy;

   modport master (
      output sclk, cs_n, mosi,
      input  miso, cmd_valid, cmd_byte, busy
   );

   modport slave (
      input  sclk, cs_n, mosi,
      output miso, cmd_valid, cmd_byte, busy
   );
endinterface

// File: rtl/rdid_responder.sv
// SPI mode-0 flash stand-in answering RDID (0x9F) with a fixed JEDEC ID.
// SPI pins are oversampled in the clk domain, so sclk must be well below clk/2.
module rdid_responder #(
   parameter logic [23:0] JEDEC_ID    = 24'h20BA18,
   parameter logic [7:0]  RDID_OPCODE = 8'h9F
) (
   input  logic            clk_i,
   input  logic            reset_i,
   rdid_responder_if.slave bus
);

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_CMD    = 2'd1;
   localparam logic [1:0] ST_RESP   = 2'd2;
   localparam logic [1:0] ST_IGNORE = 2'd3;

   // [0],[1] are the synchronizer, [2] is the previous synced value for edge detect.
   // mosi gets a third stage too so it stays aligned with the sclk edge pulses.
   logic [2:0]  sclk_s_q, cs_s_q, mosi_s_q;
   logic        sclk_rise_q, sclk_fall_q, cs_fall_q, cs_rise_q;

   logic [1:0]  state_q, state_d;
   logic [2:0]  cnt_q, cnt_d;
   logic [7:0]  op_q, op_d;
   logic [23:0] id_q, id_d;
   logic        miso_q, miso_d;
   logic [7:0]  cmd_byte_q, cmd_byte_d;
   logic        cmd_valid_q, cmd_valid_d;
   logic [7:0]  op_next;

   // Synchronize pins and register edge pulses; reset loads idle pin levels so no edge fires on release.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         sclk_s_q    <= 3'b000;
         cs_s_q      <= 3'b111;
         mosi_s_q    <= 3'b000;
         sclk_rise_q <= 1'b0;
         sclk_fall_q <= 1'b0;
         cs_fall_q   <= 1'b0;
         cs_rise_q   <= 1'b0;
      end else begin
         sclk_s_q    <= {sclk_s_q[1:0], bus.sclk};
         cs_s_q      <= {cs_s_q[1:0], bus.cs_n};
         mosi_s_q    <= {mosi_s_q[1:0], bus.mosi};
         sclk_rise_q <= sclk_s_q[1] & ~sclk_s_q[2];
         sclk_fall_q <= ~sclk_s_q[1] & sclk_s_q[2];
         cs_fall_q   <= ~cs_s_q[1] & cs_s_q[2];
         cs_rise_q   <= cs_s_q[1] & ~cs_s_q[2];
      end
   end

   // Next-state logic: opcode capture, then ID shift-out or ignore until cs_n rises.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      op_d        = op_q;
      id_d        = id_q;
      miso_d      = miso_q;
      cmd_byte_d  = cmd_byte_q;
      cmd_valid_d = 1'b0;
      op_next     = {op_q[6:0], mosi_s_q[2]};

      if (cs_rise_q) begin
         // Deselect wins over any simultaneous sclk edge and drops a partial opcode.
         state_d = ST_IDLE;
         cnt_d   = 3'd0;
         op_d    = 8'h00;
         miso_d  = 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               miso_d = 1'b0;
               cnt_d  = 3'd0;
               op_d   = 8'h00;
               if (cs_fall_q) state_d = ST_CMD;
            end
            ST_CMD: begin
               miso_d = 1'b0;
               if (sclk_rise_q) begin
                  op_d  = op_next;
                  cnt_d = cnt_q + 3'd1;
                  if (cnt_q == 3'd7) begin
                     cmd_byte_d  = op_next;
                     cmd_valid_d = 1'b1;
                     id_d        = JEDEC_ID;
                     state_d     = (op_next == RDID_OPCODE) ? ST_RESP : ST_IGNORE;
                  end
               end
            end
            ST_RESP: begin
               // Zero-fill behind the shifted bits so the ID does not wrap.
               if (sclk_fall_q) begin
                  miso_d = id_q[23];
                  id_d   = {id_q[22:0], 1'b0};
               end
            end
            ST_IGNORE: miso_d = 1'b0;
            default: begin
               state_d = ST_IDLE;
               miso_d  = 1'b0;
            end
         endcase
      end
   end

   // State registers.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q     <= ST_IDLE;
         cnt_q       <= 3'd0;
         op_q        <= 8'h00;
         id_q        <= 24'h000000;
         miso_q      <= 1'b0;
         cmd_byte_q  <= 8'h00;
         cmd_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         op_q        <= op_d;
         id_q        <= id_d;
         miso_q      <= miso_d;
         cmd_byte_q  <= cmd_byte_d;
         cmd_valid_q <= cmd_valid_d;
      end
   end

   assign bus.miso      = miso_q;
   assign bus.cmd_valid = cmd_valid_q;
   assign bus.cmd_byte  = cmd_byte_q;
   assign bus.busy      = ~cs_s_q[2];

endmodule

// File: tb/tb_rdid_responder.sv
// Bench for rdid_responder: drives SPI mode-0 frames at clk/8, collects miso
// bytes after the opcode and checks them against a queue of expected bytes.
module tb_rdid_responder;
   logic clk = 1'b0;
   logic reset;
   int   total = 0;
   int   bad = 0;

   rdid_responder_if bus ();

   rdid_responder dut (
      .clk_i  (clk),
      .reset_i(reset),
      .bus    (bus)
   );

   always #5 clk = ~clk;

   logic [23:0] id_ref = 24'h20BA18;
   logic [7:0]  exp_q[$];
   logic [7:0]  got_q[$];
   int          bitn = 0;
   logic [7:0]  sh = 8'h00;

   // cmd_valid monitor, sampled away from the active edge
   int          cv_cnt = 0;
   logic [7:0]  cv_byte = 8'h00;
   always @(negedge clk) begin
      if (bus.cmd_valid === 1'b1) begin
         cv_cnt  <= cv_cnt + 1;
         cv_byte <= bus.cmd_byte;
      end
   end

   task automatic cs_low();
      bus.cs_n = 1'b0;
      bitn = 0;
      repeat (6) @(negedge clk);
   endtask

   task automatic cs_high();
      bus.cs_n = 1'b1;
      bitn = 0;
      repeat (8) @(negedge clk);
   endtask

   // one sclk period; miso is sampled as the initiator raises sclk
   task automatic sck(input logic mo);
      bus.mosi = mo;
      repeat (4) @(negedge clk);
      bus.sclk = 1'b1;
      bitn++;
      if (bitn > 8) begin
         sh = {sh[6:0], bus.miso};
         if (((bitn - 8) % 8) == 0) got_q.push_back(sh);
      end
      repeat (4) @(negedge clk);
      bus.sclk = 1'b0;
   endtask

   task automatic send_bits(input logic [7:0] b, input int n);
      logic [7:0] v;
      v = b;
      for (int i = 0; i < n; i++) sck(v[7-i]);
   endtask

   task automatic push_exp(input logic [7:0] op, input int nbytes);
      logic [23:0] idv;
      idv = id_ref;
      for (int k = 0; k < nbytes; k++) begin
         if (op == 8'h9F && k < 3) exp_q.push_back(idv[23-8*k -: 8]);
         else exp_q.push_back(8'h00);
      end
   endtask

   task automatic frame(input logic [7:0] op, input int nbytes);
      push_exp(op, nbytes);
      cs_low();
      send_bits(op, 8);
      for (int i = 0; i < nbytes * 8; i++) sck(1'b0);
      cs_high();
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (3) @(negedge clk);
      total++; if (bus.miso !== 1'b0) begin bad++; $display("FAIL reset_miso got=%b exp=0", bus.miso); end
      total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
      total++; if (bus.cmd_byte !== 8'h00) begin bad++; $display("FAIL reset_cmd_byte got=%h exp=00", bus.cmd_byte); end
      reset = 1'b0;
      repeat (12) @(negedge clk);
      total++; if (cv_cnt !== 0) begin bad++; $display("FAIL reset_no_cmd_valid got=%0d exp=0", cv_cnt); end
      total++; if (bus.miso !== 1'b0) begin bad++; $display("FAIL post_reset_miso got=%b exp=0", bus.miso); end
   endtask

   task automatic test_rdid();
      int c0;
      logic [7:0] e, g;
      c0 = cv_cnt;
      push_exp(8'h9F, 4);
      cs_low();
      total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL rdid_busy got=%b exp=1", bus.busy); end
      send_bits(8'h9F, 8);
      for (int i = 0; i < 32; i++) sck(1'b0);
      cs_high();
      total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL rdid_busy_end got=%b exp=0", bus.busy); end
      total++; if (cv_cnt !== c0 + 1) begin bad++; $display("FAIL rdid_cv_count got=%0d exp=%0d", cv_cnt - c0, 1); end
      total++; if (cv_byte !== 8'h9F) begin bad++; $display("FAIL rdid_cmd_byte got=%h exp=9f", cv_byte); end
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front(); total++;
         if (got_q.size() == 0) begin bad++; $display("FAIL rdid_byte missing exp=%h", e); end
         else begin g = got_q.pop_front(); if (g !== e) begin bad++; $display("FAIL rdid_byte got=%h exp=%h", g, e); end end
      end
      total++; if (got_q.size() !== 0) begin bad++; $display("FAIL rdid_extra_bytes got=%0d exp=0", got_q.size()); got_q.delete(); end
   endtask

   task automatic test_other_opcode();
      int c0;
      logic [7:0] e, g;
      c0 = cv_cnt;
      frame(8'h05, 3);
      total++; if (cv_cnt !== c0 + 1) begin bad++; $display("FAIL other_cv_count got=%0d exp=1", cv_cnt - c0); end
      total++; if (cv_byte !== 8'h05) begin bad++; $display("FAIL other_cmd_byte got=%h exp=05", cv_byte); end
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front(); total++;
         if (got_q.size() == 0) begin bad++; $display("FAIL other_byte missing exp=%h", e); end
         else begin g = got_q.pop_front(); if (g !== e) begin bad++; $display("FAIL other_byte got=%h exp=%h", g, e); end end
      end
      got_q.delete();
   endtask

   task automatic test_abort_opcode();
      int c0;
      logic [7:0] e, g;
      c0 = cv_cnt;
      cs_low();
      send_bits(8'h9F, 5);
      cs_high();
      total++; if (cv_cnt !== c0) begin bad++; $display("FAIL abort_op_cv got=%0d exp=0", cv_cnt - c0); end
      frame(8'h9F, 3);
      total++; if (cv_cnt !== c0 + 1) begin bad++; $display("FAIL abort_op_next_cv got=%0d exp=1", cv_cnt - c0); end
      total++; if (cv_byte !== 8'h9F) begin bad++; $display("FAIL abort_op_cmd_byte got=%h exp=9f", cv_byte); end
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front(); total++;
         if (got_q.size() == 0) begin bad++; $display("FAIL abort_op_byte missing exp=%h", e); end
         else begin g = got_q.pop_front(); if (g !== e) begin bad++; $display("FAIL abort_op_byte got=%h exp=%h", g, e); end end
      end
      got_q.delete();
   endtask

   task automatic test_abort_resp();
      logic [7:0] e, g;
      push_exp(8'h9F, 1);
      cs_low();
      send_bits(8'h9F, 8);
      for (int i = 0; i < 10; i++) sck(1'b0);
      cs_high();
      frame(8'h9F, 3);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front(); total++;
         if (got_q.size() == 0) begin bad++; $display("FAIL abort_resp_byte missing exp=%h", e); end
         else begin g = got_q.pop_front(); if (g !== e) begin bad++; $display("FAIL abort_resp_byte got=%h exp=%h", g, e); end end
      end
      got_q.delete();
   endtask

   task automatic test_reset_mid();
      int c0;
      logic [7:0] e, g;
      push_exp(8'h9F, 1);
      cs_low();
      send_bits(8'h9F, 8);
      for (int i = 0; i < 12; i++) sck(1'b0);
      reset = 1'b1;
      @(negedge clk);
      total++; if (bus.miso !== 1'b0) begin bad++; $display("FAIL rst_mid_miso got=%b exp=0", bus.miso); end
      total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL rst_mid_busy got=%b exp=0", bus.busy); end
      total++; if (bus.cmd_byte !== 8'h00) begin bad++; $display("FAIL rst_mid_cmd_byte got=%h exp=00", bus.cmd_byte); end
      @(negedge clk);
      reset = 1'b0;
      repeat (4) @(negedge clk);
      cs_high();
      c0 = cv_cnt;
      frame(8'h9F, 3);
      total++; if (cv_cnt !== c0 + 1) begin bad++; $display("FAIL rst_mid_cv got=%0d exp=1", cv_cnt - c0); end
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front(); total++;
         if (got_q.size() == 0) begin bad++; $display("FAIL rst_mid_byte missing exp=%h", e); end
         else begin g = got_q.pop_front(); if (g !== e) begin bad++; $display("FAIL rst_mid_byte got=%h exp=%h", g, e); end end
      end
      got_q.delete();
   endtask

   task automatic test_back_to_back();
      int c0;
      logic [7:0] e, g;
      c0 = cv_cnt;
      frame(8'h9F, 3);
      frame(8'h9F, 3);
      total++; if (cv_cnt !== c0 + 2) begin bad++; $display("FAIL b2b_cv got=%0d exp=2", cv_cnt - c0); end
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front(); total++;
         if (got_q.size() == 0) begin bad++; $display("FAIL b2b_byte missing exp=%h", e); end
         else begin g = got_q.pop_front(); if (g !== e) begin bad++; $display("FAIL b2b_byte got=%h exp=%h", g, e); end end
      end
      got_q.delete();
   endtask

   initial begin
      reset    = 1'b1;
      bus.sclk = 1'b0;
      bus.cs_n = 1'b1;
      bus.mosi = 1'b0;
      test_reset();
      test_rdid();
      test_other_opcode();
      test_abort_opcode();
      test_abort_resp();
      test_reset_mid();
      test_back_to_back();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/rdid_responder.md
# rdid_responder

SPI-mode-0 flash responder for the Read Identification (RDID, 0x9F) instruction: the far end of the RDID initiator path. Oversamples the SPI pins in the system clock domain, shifts in the 8-bit opcode, and on 0x9F returns the 24-bit JEDEC ID MSB-first on MISO. It serves as a synthesizable flash stand-in for board bring-up and as the bench partner for the RDID initiator.

## Interface
- JEDEC_ID, 24'h20BA18, ID returned MSB-first: manufacturer, memory type, capacity.
- RDID_OPCODE, 8'h9F, opcode that triggers the ID response.
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- sclk  input  1  SPI clock from initiator, asynchronous to clk, idle low (mode 0).
- cs_n  input  1  SPI chip select, active low, asynchronous.
- mosi  input  1  SPI data in, asynchronous.
- miso  output  1  SPI data out; driven 0 when not returning ID bits.
- cmd_valid  output  1  one-clk pulse when the 8th opcode bit is captured.
- cmd_byte  output  8  last captured opcode, held until next capture.
- busy  output  1  high while cs_n (synchronized) is low.

## Operation
- Input conditioning: sclk, cs_n, mosi each pass through a 2-flop synchronizer; a third sclk/cs_n flop gives edge detection: sclk_rise, sclk_fall, cs_fall, cs_rise.
- States: IDLE, CMD, RESP, IGNORE.
- IDLE: miso=0, bit counter=0. cs_fall -> CMD.
- CMD: on each sclk_rise shift synced mosi into opcode register MSB-first, counter++. On 8th sclk_rise: cmd_byte <= opcode, cmd_valid=1 for one clk; if opcode==RDID_OPCODE -> RESP, else -> IGNORE.
- RESP: 24-bit shift register loaded with JEDEC_ID on entry. Each sclk_fall drives next bit on miso (first sclk_fall after opcode drives bit 23). After bit 0 has been driven, the next sclk_fall drives 0; all further bits are 0 (no wrap).
- IGNORE: miso=0; sclk edges ignored.
- cs_rise in any state -> IDLE next clk, miso=0, counters cleared; partial opcode discarded with no cmd_valid.
- cs_rise and sclk edge in same clk: cs_rise wins.
- busy = synced cs_n inverted; independent of state.
- Reset: state IDLE, miso=0, cmd_valid=0, cmd_byte=8'h00, busy=0, synchronizer flops loaded to idle levels (sclk=0, cs_n=1, mosi=0) so no edge fires on reset release.

## Timing
- Requirement on initiator: sclk high and low phases each >= 4 clk periods; cs_n setup to first sclk rise >= 4 clk; mosi stable from 2 clk before to 2 clk after sclk rise.
- Detection latency: pin edge -> internal edge pulse = 3 clk (2 sync + 1 edge register).
- miso updates on the clk after sclk_fall is detected: 4 clk after the sclk pin falls, ensuring the new bit is stable well before the next rising sclk.
- cmd_valid asserts 4 clk after the 8th sclk pin rise.
- busy follows cs_n pin with 3 clk latency.
- A full RDID transaction is 32 sclk cycles; 24 miso bits are valid on sclk rises 9..32.

## Test plan
- Reset released with pins idle -> miso=0, busy=0, cmd_valid never pulses, cmd_byte=0x00.
- cs_n low, opcode 0x9F, 24 further sclk cycles at clk/8 -> cmd_valid once, cmd_byte=0x9F, initiator samples 0x20,0xBA,0x18; 8 extra sclks return 0x00.
- Opcode 0x05 then 24 sclks -> cmd_valid once, cmd_byte=0x05, miso 0 throughout, state IGNORE until cs_n high.
- cs_n raised after 5 opcode bits, then new transaction with 0x9F -> no cmd_valid for aborted frame; second frame returns 0x20BA18 correctly.
- cs_n raised after 10 ID bits, reasserted with 0x9F -> response restarts from bit 23 (0x20,0xBA,0x18).
- reset asserted mid-RESP (after 12 ID bits) -> next clk miso=0, state IDLE; after cs_n cycle, fresh 0x9F frame returns full ID.
